accel_mag_requester: RTL and testbench
======================================

ACCEL_MAG_REQUESTER -- requirements
Module: accel_mag_requester

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 64: maximum cycles spent waiting for the magnitude engine result.
REQ-002 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-003 Port reset_n, input, 1: synchronous, active-low reset.
REQ-004 Ports s_valid input 1 and s_ready output 1: sample-side valid/ready handshake.
REQ-005 Ports s_x, s_y, s_z, input, 16 each: signed two's-complement accelerometer axes.
REQ-006 Port eng_start, output, 1: one-cycle start pulse to the magnitude engine.
REQ-007 Ports eng_x, eng_y, eng_z, output, 16 each: unsigned axis magnitudes presented to the engine.
REQ-008 Ports eng_magnitude input 16 and eng_valid input 1: engine result and its qualifier.
REQ-009 Ports r_valid output 1 and r_ready input 1: result-side valid/ready handshake.
REQ-010 Port r_magnitude, output, 16: captured magnitude.
REQ-011 Port r_seq, output, 8: sequence tag of the sample that produced the result.
REQ-012 Port r_timeout, output, 1: result produced by the timeout path.
REQ-013 Port timeout_count, output, 8: saturating count of timeouts since reset.

Function
REQ-014 The FSM SHALL have states IDLE, ISSUE, WAIT, HOLD.
REQ-015 s_ready SHALL be 1 only in IDLE; a sample is accepted when s_valid and s_ready are both 1, moving IDLE->ISSUE.
REQ-016 On acceptance: eng_x/eng_y/eng_z SHALL register |s_x|/|s_y|/|s_z|; -32768 saturates to 32767 (0x7FFF).
REQ-017 eng_x/eng_y/eng_z SHALL hold stable from ISSUE until the FSM returns to IDLE.
REQ-018 eng_start SHALL be 1 for exactly the one ISSUE cycle (acceptance edge T, eng_start high during cycle T+1); ISSUE->WAIT unconditionally.
REQ-019 eng_valid SHALL be sampled only in WAIT; eng_valid in IDLE, ISSUE or HOLD SHALL be ignored.
REQ-020 In WAIT with eng_valid=1: r_magnitude<=eng_magnitude, r_timeout<=0, go HOLD; r_valid high the following cycle.
REQ-021 A WAIT cycle counter SHALL clear on entry to WAIT and increment each WAIT cycle without eng_valid.
REQ-022 When the counter reaches TIMEOUT_CYCLES without eng_valid: r_magnitude<=0xFFFF, r_timeout<=1, timeout_count increments (saturating at 255), go HOLD.
REQ-023 eng_valid in the same cycle the counter reaches TIMEOUT_CYCLES SHALL take priority: normal result, no timeout.
REQ-024 r_valid SHALL be 1 exactly in HOLD; r_magnitude, r_seq, r_timeout stable while r_valid=1 and r_ready=0.
REQ-025 HOLD with r_ready=1 SHALL return to IDLE; s_ready becomes 1 the next cycle (no same-cycle pass-through).
REQ-026 Sequence counter SHALL increment on every accepted sample, wrapping 255->0; r_seq carries the value at that sample's acceptance (first sample after reset = 0).
REQ-027 Minimum latency: engine result at WAIT cycle N -> r_valid at edge N+1; throughput ≤ one sample per (engine latency + 4) cycles.

Reset
REQ-028 With reset_n=0 at a clk edge: FSM->IDLE; s_ready=0 during reset, 1 the first cycle after release; eng_start=0, eng_x/y/z=0, r_valid=0, r_magnitude=0, r_seq=0, r_timeout=0, timeout_count=0, sequence and WAIT counters=0.
REQ-029 Reset asserted in any state (incl. mid-WAIT) SHALL abandon the transaction; a late eng_valid after release SHALL be ignored (FSM in IDLE).

Verification
REQ-030 s=(3,4,0), engine model returns 5 after 10 cycles -> one eng_start pulse, eng=(3,4,0), r_valid with r_magnitude=5, r_seq=0, r_timeout=0.
REQ-031 s=(-3,-4,-32768) -> eng_x=3, eng_y=4, eng_z=32767 held through WAIT.
REQ-032 Engine never asserts eng_valid -> r_valid after exactly TIMEOUT_CYCLES WAIT cycles, r_magnitude=0xFFFF, r_timeout=1, timeout_count=1.
REQ-033 r_ready held 0 for 5 cycles in HOLD -> r_valid and outputs stable, s_ready=0, no eng_start; r_ready=1 -> IDLE, next sample gets r_seq+1.
REQ-034 reset_n=0 for one cycle mid-WAIT, then eng_valid pulses -> no r_valid, all outputs at reset values, next sample tagged r_seq=0.
REQ-035 257 back-to-back samples with r_ready=1 -> r_seq runs 0..255 then 0; eng_valid during ISSUE never completes a transaction.

Source files
------------

// File: rtl/accel_mag_requester.sv
// Accelerometer magnitude requester.
// Accepts one signed 3-axis sample, hands the saturated absolute values to an
// external magnitude engine, waits a bounded time for its answer and presents
// the result (or a timeout marker) on a valid/ready result port.
module accel_mag_requester #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_x,
  input  logic [15:0] s_y,
  input  logic [15:0] s_z,
  output logic        eng_start,
  output logic [15:0] eng_x,
  output logic [15:0] eng_y,
  output logic [15:0] eng_z,
  input  logic [15:0] eng_magnitude,
  input  logic        eng_valid,
  output logic        r_valid,
  input  logic        r_ready,
  output logic [15:0] r_magnitude,
  output logic [7:0]  r_seq,
  output logic        r_timeout,
  output logic [7:0]  timeout_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  // Counter wide enough to hold TIMEOUT_CYCLES itself.
  localparam int              CW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]   WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [7:0]    seq_q, seq_d;
  logic [15:0]   eng_x_q, eng_x_d;
  logic [15:0]   eng_y_q, eng_y_d;
  logic [15:0]   eng_z_q, eng_z_d;
  logic [15:0]   r_mag_q, r_mag_d;
  logic [7:0]    r_seq_q, r_seq_d;
  logic          r_timeout_q, r_timeout_d;
  logic [7:0]    to_cnt_q, to_cnt_d;
  logic          accept;

  // Absolute value; -32768 has no positive twin so it clamps to 32767.
  function automatic logic [15:0] absSat(input logic [15:0] v);
    if (v == 16'h8000) begin
      return 16'h7FFF;
    end else if (v[15]) begin
      return 16'h0000 - v;
    end else begin
      return v;
    end
  endfunction

  // Ready is withheld while reset is asserted so nothing is accepted then.
  assign s_ready       = (state_q == IDLE) && reset_n;
  assign accept        = s_valid && s_ready;
  assign eng_start     = (state_q == ISSUE);
  assign r_valid       = (state_q == HOLD);
  assign eng_x         = eng_x_q;
  assign eng_y         = eng_y_q;
  assign eng_z         = eng_z_q;
  assign r_magnitude   = r_mag_q;
  assign r_seq         = r_seq_q;
  assign r_timeout     = r_timeout_q;
  assign timeout_count = to_cnt_q;

  // Next-state logic: engine result is only looked at in WAIT, and a result
  // arriving on the last allowed cycle wins over the timeout.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    seq_d       = seq_q;
    eng_x_d     = eng_x_q;
    eng_y_d     = eng_y_q;
    eng_z_d     = eng_z_q;
    r_mag_d     = r_mag_q;
    r_seq_d     = r_seq_q;
    r_timeout_d = r_timeout_q;
    to_cnt_d    = to_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ISSUE;
          eng_x_d = absSat(s_x);
          eng_y_d = absSat(s_y);
          eng_z_d = absSat(s_z);
          r_seq_d = seq_q;
          seq_d   = seq_q + 8'd1;
        end
      end
      ISSUE: begin
        state_d    = WAIT;
        wait_cnt_d = '0;
      end
      WAIT: begin
        if (eng_valid) begin
          r_mag_d     = eng_magnitude;
          r_timeout_d = 1'b0;
          state_d     = HOLD;
        end else if (wait_cnt_q == WAIT_LAST) begin
          wait_cnt_d  = wait_cnt_q + CW'(1);
          r_mag_d     = 16'hFFFF;
          r_timeout_d = 1'b1;
          if (to_cnt_q != 8'hFF) begin
            to_cnt_d = to_cnt_q + 8'd1;
          end
          state_d     = HOLD;
        end else begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end
      HOLD: begin
        if (r_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      seq_q       <= 8'd0;
      eng_x_q     <= 16'd0;
      eng_y_q     <= 16'd0;
      eng_z_q     <= 16'd0;
      r_mag_q     <= 16'd0;
      r_seq_q     <= 8'd0;
      r_timeout_q <= 1'b0;
      to_cnt_q    <= 8'd0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      seq_q       <= seq_d;
      eng_x_q     <= eng_x_d;
      eng_y_q     <= eng_y_d;
      eng_z_q     <= eng_z_d;
      r_mag_q     <= r_mag_d;
      r_seq_q     <= r_seq_d;
      r_timeout_q <= r_timeout_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

endmodule

// File: tb/tb_accel_mag_requester.sv
// Directed testbench for accel_mag_requester: a vector table of single
// transactions plus hand-written reset-in-WAIT and back-to-back sequences.
module tb_accel_mag_requester;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_x, s_y, s_z;
  logic        eng_start;
  logic [15:0] eng_x, eng_y, eng_z;
  logic [15:0] eng_magnitude;
  logic        eng_valid;
  logic        r_valid;
  logic        r_ready;
  logic [15:0] r_magnitude;
  logic [7:0]  r_seq;
  logic        r_timeout;
  logic [7:0]  timeout_count;

  typedef struct {
    logic [15:0] x, y, z;
    int          lat;
    logic [15:0] mag;
    logic [15:0] ex, ey, ez;
    logic [15:0] expMag;
    logic        expTo;
    int          hold;
  } vec_t;

  vec_t vecs[6];
  int   total = 0;
  int   bad = 0;
  int   expSeq = 0;
  int   expToCount = 0;

  accel_mag_requester #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_x(s_x), .s_y(s_y), .s_z(s_z),
    .eng_start(eng_start),
    .eng_x(eng_x), .eng_y(eng_y), .eng_z(eng_z),
    .eng_magnitude(eng_magnitude), .eng_valid(eng_valid),
    .r_valid(r_valid), .r_ready(r_ready),
    .r_magnitude(r_magnitude), .r_seq(r_seq),
    .r_timeout(r_timeout), .timeout_count(timeout_count)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Hard stop in case the design wedges somewhere unexpected.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time exhausted");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic applyReset(input string tag);
    reset_n = 1'b0;
    s_valid = 1'b0;
    eng_valid = 1'b0;
    r_ready = 1'b0;
    tick();
    tick();
    checkOutput({tag, " rst s_ready"}, 32'(s_ready), 0);
    checkOutput({tag, " rst eng_start"}, 32'(eng_start), 0);
    checkOutput({tag, " rst eng_x"}, 32'(eng_x), 0);
    checkOutput({tag, " rst eng_z"}, 32'(eng_z), 0);
    checkOutput({tag, " rst r_valid"}, 32'(r_valid), 0);
    checkOutput({tag, " rst r_magnitude"}, 32'(r_magnitude), 0);
    checkOutput({tag, " rst r_seq"}, 32'(r_seq), 0);
    checkOutput({tag, " rst r_timeout"}, 32'(r_timeout), 0);
    checkOutput({tag, " rst timeout_count"}, 32'(timeout_count), 0);
    reset_n = 1'b1;
    #1;
    checkOutput({tag, " s_ready after release"}, 32'(s_ready), 1);
    expSeq = 0;
    expToCount = 0;
  endtask

  // One full transaction: accept, ISSUE, WAIT with engine answer at WAIT
  // cycle v.lat (0 or beyond the limit means never), HOLD for v.hold cycles.
  task automatic applyStimulus(input vec_t v, input string tag);
    int   waitCycles;
    bit   done;
    int   expWait;
    logic modelTo;
    checkOutput({tag, " s_ready idle"}, 32'(s_ready), 1);
    s_valid = 1'b1;
    s_x = v.x;
    s_y = v.y;
    s_z = v.z;
    tick();
    s_valid = 1'b0;
    s_x = 16'h5555;
    s_y = 16'hAAAA;
    s_z = 16'h8000;
    checkOutput({tag, " eng_start issue"}, 32'(eng_start), 1);
    checkOutput({tag, " s_ready issue"}, 32'(s_ready), 0);
    checkOutput({tag, " eng_x"}, 32'(eng_x), 32'(v.ex));
    checkOutput({tag, " eng_y"}, 32'(eng_y), 32'(v.ey));
    checkOutput({tag, " eng_z"}, 32'(eng_z), 32'(v.ez));
    tick();
    checkOutput({tag, " eng_start wait"}, 32'(eng_start), 0);
    waitCycles = 0;
    done = 1'b0;
    while (!done && waitCycles < TIMEOUT + 10) begin
      waitCycles++;
      if (waitCycles == v.lat) begin
        eng_valid = 1'b1;
        eng_magnitude = v.mag;
      end
      tick();
      eng_valid = 1'b0;
      eng_magnitude = 16'hBEEF;
      done = r_valid;
    end
    modelTo = !(v.lat >= 1 && v.lat <= TIMEOUT);
    expWait = modelTo ? TIMEOUT : v.lat;
    if (modelTo && expToCount < 255) expToCount++;
    checkOutput({tag, " r_valid seen"}, 32'(done), 1);
    checkOutput({tag, " wait cycles"}, 32'(waitCycles), 32'(expWait));
    checkOutput({tag, " r_magnitude"}, 32'(r_magnitude), 32'(v.expMag));
    checkOutput({tag, " r_timeout"}, 32'(r_timeout), 32'(v.expTo));
    checkOutput({tag, " r_timeout model"}, 32'(r_timeout), 32'(modelTo));
    checkOutput({tag, " r_seq"}, 32'(r_seq), 32'(expSeq[7:0]));
    checkOutput({tag, " timeout_count"}, 32'(timeout_count), 32'(expToCount));
    checkOutput({tag, " eng_x held"}, 32'(eng_x), 32'(v.ex));
    checkOutput({tag, " eng_z held"}, 32'(eng_z), 32'(v.ez));
    for (int h = 0; h < v.hold; h++) begin
      eng_valid = 1'b1;
      eng_magnitude = 16'h0F0F;
      tick();
      checkOutput({tag, " hold r_valid"}, 32'(r_valid), 1);
      checkOutput({tag, " hold r_magnitude"}, 32'(r_magnitude), 32'(v.expMag));
      checkOutput({tag, " hold r_seq"}, 32'(r_seq), 32'(expSeq[7:0]));
      checkOutput({tag, " hold r_timeout"}, 32'(r_timeout), 32'(v.expTo));
      checkOutput({tag, " hold s_ready"}, 32'(s_ready), 0);
      checkOutput({tag, " hold eng_start"}, 32'(eng_start), 0);
    end
    eng_valid = 1'b0;
    r_ready = 1'b1;
    #1;
    checkOutput({tag, " s_ready same cycle"}, 32'(s_ready), 0);
    tick();
    r_ready = 1'b0;
    checkOutput({tag, " r_valid released"}, 32'(r_valid), 0);
    checkOutput({tag, " s_ready released"}, 32'(s_ready), 1);
    expSeq = (expSeq + 1) % 256;
  endtask

  initial begin
    reset_n = 1'b0;
    s_valid = 1'b0;
    s_x = 16'd0;
    s_y = 16'd0;
    s_z = 16'd0;
    eng_valid = 1'b0;
    eng_magnitude = 16'd0;
    r_ready = 1'b0;

    vecs[0] = '{16'd3, 16'd4, 16'd0, 10, 16'd5,
                16'd3, 16'd4, 16'd0, 16'd5, 1'b0, 0};
    vecs[1] = '{16'hFFFD, 16'hFFFC, 16'h8000, 20, 16'd7,
                16'd3, 16'd4, 16'h7FFF, 16'd7, 1'b0, 5};
    vecs[2] = '{16'h7FFF, 16'hFFFF, 16'h8001, 1, 16'h0100,
                16'h7FFF, 16'd1, 16'h7FFF, 16'h0100, 1'b0, 0};
    vecs[3] = '{16'd100, 16'd200, 16'd300, 0, 16'd0,
                16'h0064, 16'h00C8, 16'h012C, 16'hFFFF, 1'b1, 2};
    vecs[4] = '{16'd0, 16'd0, 16'd0, 64, 16'd0,
                16'd0, 16'd0, 16'd0, 16'd0, 1'b0, 0};
    vecs[5] = '{16'hFF9C, 16'h0032, 16'hFFFE, 65, 16'h1111,
                16'h0064, 16'h0032, 16'h0002, 16'hFFFF, 1'b1, 0};

    applyReset("init");

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i], $sformatf("v%0d", i));
    end

    // Reset in the middle of WAIT, then a late engine answer.
    s_valid = 1'b1;
    s_x = 16'd10;
    s_y = 16'd20;
    s_z = 16'd30;
    tick();
    s_valid = 1'b0;
    tick();
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    checkOutput("midrst r_valid", 32'(r_valid), 0);
    checkOutput("midrst eng_x", 32'(eng_x), 0);
    checkOutput("midrst eng_y", 32'(eng_y), 0);
    checkOutput("midrst r_seq", 32'(r_seq), 0);
    checkOutput("midrst r_magnitude", 32'(r_magnitude), 0);
    checkOutput("midrst r_timeout", 32'(r_timeout), 0);
    checkOutput("midrst timeout_count", 32'(timeout_count), 0);
    checkOutput("midrst s_ready low", 32'(s_ready), 0);
    reset_n = 1'b1;
    expSeq = 0;
    expToCount = 0;
    for (int k = 0; k < 3; k++) begin
      eng_valid = 1'b1;
      eng_magnitude = 16'h0077;
      tick();
      checkOutput("late eng_valid r_valid", 32'(r_valid), 0);
      checkOutput("late eng_valid s_ready", 32'(s_ready), 1);
    end
    eng_valid = 1'b0;
    applyStimulus(vecs[0], "post-midrst");

    // 257 back-to-back samples, engine pulsing valid during ISSUE too.
    applyReset("b2b");
    r_ready = 1'b1;
    for (int k = 0; k < 257; k++) begin
      s_valid = 1'b1;
      s_x = 16'(k);
      s_y = 16'd1;
      s_z = 16'd2;
      tick();
      s_valid = 1'b0;
      eng_valid = 1'b1;
      eng_magnitude = 16'hDEAD;
      tick();
      eng_magnitude = 16'(k);
      tick();
      eng_valid = 1'b0;
      checkOutput($sformatf("b2b r_valid %0d", k), 32'(r_valid), 1);
      checkOutput($sformatf("b2b r_seq %0d", k), 32'(r_seq), 32'(k % 256));
      checkOutput($sformatf("b2b r_magnitude %0d", k), 32'(r_magnitude), 32'(k));
      tick();
      checkOutput($sformatf("b2b s_ready %0d", k), 32'(s_ready), 1);
    end
    r_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
